trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_if.sv | 49 ++++
 rtl/trap_ctrl.sv | 176 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Trap controller bundle: request side from the core, CSR file access
// side, and the stall / redirect outputs back to the pipeline.
`timescale 1ns/1ps

interface trap_ctrl_if;
  // trap / return requests from the core
  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret_req;

  // CSR-instruction access coming from the execute stage
  logic        inst_wr_en;
  logic        inst_wr_set;
  logic [11:0] inst_wr_reg;
  logic [31:0] inst_wr_bus;
  logic [11:0] inst_rd_reg;

  // CSR file port (read data is combinational from the file)
  logic        csr_wr_en;
  logic        csr_wr_set;
  logic [11:0] csr_wr_reg;
  logic [31:0] csr_wr_bus;
  logic [11:0] csr_rd_reg;
  logic [31:0] csr_rd_bus;

  // pipeline control
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // core + CSR file side
  modport master (
    output trap_req, trap_pc, trap_cause, mret_req,
    output inst_wr_en, inst_wr_set, inst_wr_reg, inst_wr_bus, inst_rd_reg,
    output csr_rd_bus,
    input  csr_wr_en, csr_wr_set, csr_wr_reg, csr_wr_bus, csr_rd_reg,
    input  busy, redirect_valid, redirect_pc
  );

  // trap controller side
  modport slave (
    input  trap_req, trap_pc, trap_cause, mret_req,
    input  inst_wr_en, inst_wr_set, inst_wr_reg, inst_wr_bus, inst_rd_reg,
    input  csr_rd_bus,
    output csr_wr_en, csr_wr_set, csr_wr_reg, csr_wr_bus, csr_rd_reg,
    output busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap / mret sequencer. Owns the CSR file port while a
// sequence runs (mepc, mcause, mstatus updates, mtvec / mepc fetch) and
// otherwise passes the CSR-instruction port straight through.
`timescale 1ns/1ps

module trap_ctrl (
  input  logic         clk,
  input  logic         rst,
  trap_ctrl_if.slave   tc
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_T_EPC   = 3'd1,
    ST_T_CAUSE = 3'd2,
    ST_T_STAT  = 3'd3,
    ST_T_VEC   = 3'd4,
    ST_R_STAT  = 3'd5,
    ST_R_EPC   = 3'd6
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] pc_r;
  logic [31:0] cause_r;

  logic        csr_wr_en_s;
  logic        csr_wr_set_s;
  logic [11:0] csr_wr_reg_s;
  logic [31:0] csr_wr_bus_s;
  logic [11:0] csr_rd_reg_s;
  logic        busy_s;
  logic        redirect_valid_s;
  logic [31:0] redirect_pc_s;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] old);
    return (old & ~32'h0000_1888) | {24'h00_0000, old[3], 7'h00} | 32'h0000_1800;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1, MPP stays 2'b11 (M-only core).
  function automatic logic [31:0] mret_mstatus(input logic [31:0] old);
    return (old & ~32'h0000_1888) | {28'h000_0000, old[7], 3'h0}
           | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  // State register; reset can abort a sequence at any point.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Capture the trapping pc/cause as the sequence starts so the core may move on.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r    <= 32'h0000_0000;
      cause_r <= 32'h0000_0000;
    end else if ((state_r == ST_IDLE) && tc.trap_req) begin
      pc_r    <= tc.trap_pc;
      cause_r <= tc.trap_cause;
    end else begin
      pc_r    <= pc_r;
      cause_r <= cause_r;
    end
  end

  // Sequence progression; requests only matter in IDLE and trap beats mret.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tc.trap_req) begin
          next_state_s = ST_T_EPC;
        end else if (tc.mret_req) begin
          next_state_s = ST_R_STAT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_T_EPC:   next_state_s = ST_T_CAUSE;
      ST_T_CAUSE: next_state_s = ST_T_STAT;
      ST_T_STAT:  next_state_s = ST_T_VEC;
      ST_T_VEC:   next_state_s = ST_IDLE;
      ST_R_STAT:  next_state_s = ST_R_EPC;
      ST_R_EPC:   next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // CSR port and pipeline controls; everything is held quiet while reset is low.
  always_comb begin
    csr_wr_en_s      = 1'b0;
    csr_wr_set_s     = 1'b0;
    csr_wr_reg_s     = 12'h000;
    csr_wr_bus_s     = 32'h0000_0000;
    csr_rd_reg_s     = 12'h000;
    busy_s           = 1'b0;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = 32'h0000_0000;
    if (!rst) begin
      csr_wr_en_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // the instruction port owns the CSR file, even on the request cycle
          csr_wr_en_s  = tc.inst_wr_en;
          csr_wr_set_s = tc.inst_wr_set;
          csr_wr_reg_s = tc.inst_wr_reg;
          csr_wr_bus_s = tc.inst_wr_bus;
          csr_rd_reg_s = tc.inst_rd_reg;
        end
        ST_T_EPC: begin
          busy_s       = 1'b1;
          csr_wr_en_s  = 1'b1;
          csr_wr_reg_s = CSR_MEPC;
          csr_wr_bus_s = pc_r;
        end
        ST_T_CAUSE: begin
          busy_s       = 1'b1;
          csr_wr_en_s  = 1'b1;
          csr_wr_reg_s = CSR_MCAUSE;
          csr_wr_bus_s = cause_r;
        end
        ST_T_STAT: begin
          // read-modify-write in one cycle on the combinational read path
          busy_s       = 1'b1;
          csr_rd_reg_s = CSR_MSTATUS;
          csr_wr_en_s  = 1'b1;
          csr_wr_reg_s = CSR_MSTATUS;
          csr_wr_bus_s = trap_mstatus(tc.csr_rd_bus);
        end
        ST_T_VEC: begin
          // direct mode only: the two mode bits of mtvec are dropped
          busy_s           = 1'b1;
          csr_rd_reg_s     = CSR_MTVEC;
          redirect_valid_s = 1'b1;
          redirect_pc_s    = tc.csr_rd_bus & 32'hFFFF_FFFC;
        end
        ST_R_STAT: begin
          busy_s       = 1'b1;
          csr_rd_reg_s = CSR_MSTATUS;
          csr_wr_en_s  = 1'b1;
          csr_wr_reg_s = CSR_MSTATUS;
          csr_wr_bus_s = mret_mstatus(tc.csr_rd_bus);
        end
        ST_R_EPC: begin
          busy_s           = 1'b1;
          csr_rd_reg_s     = CSR_MEPC;
          redirect_valid_s = 1'b1;
          redirect_pc_s    = tc.csr_rd_bus;
        end
        default: begin
          busy_s = 1'b0;
        end
      endcase
    end
  end

  assign tc.csr_wr_en      = csr_wr_en_s;
  assign tc.csr_wr_set     = csr_wr_set_s;
  assign tc.csr_wr_reg     = csr_wr_reg_s;
  assign tc.csr_wr_bus     = csr_wr_bus_s;
  assign tc.csr_rd_reg     = csr_rd_reg_s;
  assign tc.busy           = busy_s;
  assign tc.redirect_valid = redirect_valid_s;
  assign tc.redirect_pc    = redirect_pc_s;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: small CSR file model on the DUT's CSR port, directed
// scenarios, then randomized trap/mret/CSR traffic against a reference model.
`timescale 1ns/1ps

module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  trap_ctrl_if ifc ();

  trap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .tc  (ifc)
  );

  always #5 clk = ~clk;

  // CSR file as seen by the controller
  logic [31:0] f_mstatus, f_mtvec, f_mepc, f_mcause;
  // reference model view of the same registers
  logic [31:0] r_mstatus, r_mtvec, r_mepc, r_mcause;

  logic        exp_busy, exp_rv;
  logic [31:0] exp_pc;

  // CSR file write port
  always @(posedge clk) begin
    if (ifc.csr_wr_en) begin
      case (ifc.csr_wr_reg)
        12'h300: f_mstatus <= ifc.csr_wr_set ? (f_mstatus | ifc.csr_wr_bus) : ifc.csr_wr_bus;
        12'h305: f_mtvec   <= ifc.csr_wr_set ? (f_mtvec   | ifc.csr_wr_bus) : ifc.csr_wr_bus;
        12'h341: f_mepc    <= ifc.csr_wr_set ? (f_mepc    | ifc.csr_wr_bus) : ifc.csr_wr_bus;
        12'h342: f_mcause  <= ifc.csr_wr_set ? (f_mcause  | ifc.csr_wr_bus) : ifc.csr_wr_bus;
        default: ;
      endcase
    end
  end

  // CSR file combinational read port
  always_comb begin
    case (ifc.csr_rd_reg)
      12'h300: ifc.csr_rd_bus = f_mstatus;
      12'h305: ifc.csr_rd_bus = f_mtvec;
      12'h341: ifc.csr_rd_bus = f_mepc;
      12'h342: ifc.csr_rd_bus = f_mcause;
      default: ifc.csr_rd_bus = 32'h0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ifc.trap_req    = 1'b0;
    ifc.trap_pc     = 32'h0;
    ifc.trap_cause  = 32'h0;
    ifc.mret_req    = 1'b0;
    ifc.inst_wr_en  = 1'b0;
    ifc.inst_wr_set = 1'b0;
    ifc.inst_wr_reg = 12'h0;
    ifc.inst_wr_bus = 32'h0;
    ifc.inst_rd_reg = 12'h0;
  endtask

  task automatic inst_write(input logic [11:0] a, input logic [31:0] d);
    ifc.inst_wr_en  = 1'b1;
    ifc.inst_wr_set = 1'b0;
    ifc.inst_wr_reg = a;
    ifc.inst_wr_bus = d;
    cyc();
    clear_in();
  endtask

  function automatic logic [11:0] addr_of(input int i);
    case (i)
      0:       return 12'h300;
      1:       return 12'h305;
      2:       return 12'h341;
      3:       return 12'h342;
      default: return 12'h7C0;
    endcase
  endfunction

  task automatic test_reset();
    clear_in();
    rst = 1'b0;
    ifc.inst_wr_en  = 1'b1;
    ifc.inst_wr_reg = 12'h300;
    ifc.inst_wr_bus = 32'h1234_5678;
    ifc.trap_req    = 1'b1;
    cyc();
    cyc();
    #1;
    n_tests++;
    if ({ifc.csr_wr_en, ifc.busy, ifc.redirect_valid, ifc.redirect_pc} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr_en=%b busy=%b rv=%b rpc=%h, expected all zero",
               ifc.csr_wr_en, ifc.busy, ifc.redirect_valid, ifc.redirect_pc);
    end
    clear_in();
    rst = 1'b1;
    cyc();
    #1;
    n_tests++;
    if (ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b expected 0", ifc.busy);
    end
    inst_write(12'h300, 32'h0000_1800);
    inst_write(12'h305, 32'h8000_0100);
    inst_write(12'h341, 32'h0);
    inst_write(12'h342, 32'h0);
    n_tests++;
    if ({f_mstatus, f_mtvec} !== {32'h0000_1800, 32'h8000_0100}) begin
      n_fail++;
      $display("FAIL csr_init: got mstatus=%h mtvec=%h expected 00001800 80000100", f_mstatus, f_mtvec);
    end
  endtask

  task automatic test_trap_basic();
    ifc.trap_req   = 1'b1;
    ifc.trap_pc    = 32'h8000_0010;
    ifc.trap_cause = 32'd11;
    #1;
    n_tests++;
    if (ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_req_cycle_busy: got %b expected 0", ifc.busy);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      ifc.trap_req   = 1'b0;
      ifc.trap_pc    = 32'hFFFF_FFF0;
      ifc.trap_cause = 32'h5;
      #1;
      exp_busy = (k <= 4);
      exp_rv   = (k == 4);
      exp_pc   = (k == 4) ? 32'h8000_0100 : 32'h0;
      n_tests++;
      if ({ifc.busy, ifc.redirect_valid, ifc.redirect_pc} !== {exp_busy, exp_rv, exp_pc}) begin
        n_fail++;
        $display("FAIL trap_basic_cycle%0d: got busy=%b rv=%b rpc=%h expected busy=%b rv=%b rpc=%h",
                 k, ifc.busy, ifc.redirect_valid, ifc.redirect_pc, exp_busy, exp_rv, exp_pc);
      end
    end
    clear_in();
    n_tests++;
    if ({f_mepc, f_mcause, f_mstatus} !== {32'h8000_0010, 32'd11, 32'h0000_1800}) begin
      n_fail++;
      $display("FAIL trap_basic_csrs: got mepc=%h mcause=%h mstatus=%h expected 80000010 0000000b 00001800",
               f_mepc, f_mcause, f_mstatus);
    end
  endtask

  task automatic test_passthrough();
    ifc.inst_wr_en  = 1'b1;
    ifc.inst_wr_set = 1'b1;
    ifc.inst_wr_reg = 12'h300;
    ifc.inst_wr_bus = 32'h8;
    ifc.inst_rd_reg = 12'h305;
    #1;
    n_tests++;
    if ({ifc.csr_wr_en, ifc.csr_wr_set, ifc.csr_wr_reg, ifc.csr_wr_bus, ifc.csr_rd_reg}
        !== {1'b1, 1'b1, 12'h300, 32'h8, 12'h305}) begin
      n_fail++;
      $display("FAIL passthrough_mirror: got en=%b set=%b reg=%h bus=%h rd=%h expected 1 1 300 00000008 305",
               ifc.csr_wr_en, ifc.csr_wr_set, ifc.csr_wr_reg, ifc.csr_wr_bus, ifc.csr_rd_reg);
    end
    cyc();
    clear_in();
    n_tests++;
    if (f_mstatus !== 32'h0000_1808) begin
      n_fail++;
      $display("FAIL passthrough_set: got mstatus=%h expected 00001808", f_mstatus);
    end
  endtask

  task automatic test_trap_mret();
    ifc.trap_req   = 1'b1;
    ifc.trap_pc    = 32'h8000_0010;
    ifc.trap_cause = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      clear_in();
    end
    n_tests++;
    if (f_mstatus !== 32'h0000_1880) begin
      n_fail++;
      $display("FAIL trap_mstatus: got %h expected 00001880", f_mstatus);
    end
    ifc.mret_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      ifc.mret_req = 1'b0;
      #1;
      exp_busy = (k <= 2);
      exp_rv   = (k == 2);
      exp_pc   = (k == 2) ? 32'h8000_0010 : 32'h0;
      n_tests++;
      if ({ifc.busy, ifc.redirect_valid, ifc.redirect_pc} !== {exp_busy, exp_rv, exp_pc}) begin
        n_fail++;
        $display("FAIL mret_cycle%0d: got busy=%b rv=%b rpc=%h expected busy=%b rv=%b rpc=%h",
                 k, ifc.busy, ifc.redirect_valid, ifc.redirect_pc, exp_busy, exp_rv, exp_pc);
      end
    end
    n_tests++;
    if (f_mstatus !== 32'h0000_1888) begin
      n_fail++;
      $display("FAIL mret_mstatus: got %h expected 00001888", f_mstatus);
    end
  endtask

  task automatic test_simultaneous();
    int          n_rv;
    int          rv_k;
    logic [31:0] rv_pc;
    n_rv  = 0;
    rv_k  = 0;
    rv_pc = 32'h0;
    inst_write(12'h305, 32'h8000_0103);
    ifc.trap_req   = 1'b1;
    ifc.mret_req   = 1'b1;
    ifc.trap_pc    = 32'h8000_0020;
    ifc.trap_cause = 32'd11;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      clear_in();
      #1;
      if (ifc.redirect_valid === 1'b1) begin
        n_rv++;
        rv_k  = k;
        rv_pc = ifc.redirect_pc;
      end
    end
    n_tests++;
    if (n_rv !== 1 || rv_k !== 4 || rv_pc !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL simultaneous_redirect: got count=%0d cycle=%0d pc=%h expected 1 4 80000100",
               n_rv, rv_k, rv_pc);
    end
    n_tests++;
    if ({f_mepc, f_mstatus} !== {32'h8000_0020, 32'h0000_1880}) begin
      n_fail++;
      $display("FAIL simultaneous_csrs: got mepc=%h mstatus=%h expected 80000020 00001880", f_mepc, f_mstatus);
    end
  endtask

  task automatic test_inst_ignored();
    ifc.trap_req   = 1'b1;
    ifc.trap_pc    = 32'h8000_0040;
    ifc.trap_cause = 32'd7;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      clear_in();
      if (k == 2) begin
        ifc.inst_wr_en  = 1'b1;
        ifc.inst_wr_set = 1'b1;
        ifc.inst_wr_reg = 12'h341;
        ifc.inst_wr_bus = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if ({ifc.csr_wr_en, ifc.csr_wr_set, ifc.csr_wr_reg, ifc.csr_wr_bus} !== {1'b1, 1'b0, 12'h342, 32'd7}) begin
          n_fail++;
          $display("FAIL inst_ignored_port: got en=%b set=%b reg=%h bus=%h expected 1 0 342 00000007",
                   ifc.csr_wr_en, ifc.csr_wr_set, ifc.csr_wr_reg, ifc.csr_wr_bus);
        end
      end
    end
    n_tests++;
    if ({f_mepc, f_mcause} !== {32'h8000_0040, 32'd7}) begin
      n_fail++;
      $display("FAIL inst_ignored_csrs: got mepc=%h mcause=%h expected 80000040 00000007", f_mepc, f_mcause);
    end
  endtask

  task automatic test_reset_mid();
    int n_bad;
    n_bad = 0;
    inst_write(12'h300, 32'h0000_1808);
    inst_write(12'h342, 32'h0000_0055);
    ifc.trap_req   = 1'b1;
    ifc.trap_pc    = 32'h8000_0080;
    ifc.trap_cause = 32'd9;
    cyc();
    clear_in();
    cyc();
    rst = 1'b0;
    ifc.inst_wr_en = 1'b1;
    #1;
    n_tests++;
    if ({ifc.csr_wr_en, ifc.busy, ifc.redirect_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got wr_en=%b busy=%b rv=%b expected 000",
               ifc.csr_wr_en, ifc.busy, ifc.redirect_valid);
    end
    cyc();
    rst = 1'b1;
    clear_in();
    #1;
    n_tests++;
    if (ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got busy=%b expected 0", ifc.busy);
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (ifc.redirect_valid !== 1'b0 || ifc.csr_wr_en !== 1'b0) n_bad++;
    end
    n_tests++;
    if (n_bad !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", n_bad);
    end
    n_tests++;
    if ({f_mstatus, f_mcause, f_mepc} !== {32'h0000_1808, 32'h55, 32'h8000_0080}) begin
      n_fail++;
      $display("FAIL reset_mid_csrs: got mstatus=%h mcause=%h mepc=%h expected 00001808 00000055 80000080",
               f_mstatus, f_mcause, f_mepc);
    end
  endtask

  task automatic test_back_to_back();
    ifc.trap_req   = 1'b1;
    ifc.trap_pc    = 32'h8000_00A0;
    ifc.trap_cause = 32'd2;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      clear_in();
    end
    #1;
    n_tests++;
    if (ifc.redirect_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_trap_redirect: got rv=%b expected 1", ifc.redirect_valid);
    end
    cyc();
    ifc.mret_req = 1'b1;
    #1;
    n_tests++;
    if (ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: got busy=%b expected 0", ifc.busy);
    end
    cyc();
    clear_in();
    #1;
    n_tests++;
    if (ifc.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_mret_accepted: got busy=%b expected 1", ifc.busy);
    end
    cyc();
    #1;
    n_tests++;
    if ({ifc.redirect_valid, ifc.redirect_pc} !== {1'b1, 32'h8000_00A0}) begin
      n_fail++;
      $display("FAIL b2b_mret_redirect: got rv=%b rpc=%h expected 1 800000a0", ifc.redirect_valid, ifc.redirect_pc);
    end
    cyc();
    n_tests++;
    if (f_mstatus !== 32'h0000_1888) begin
      n_fail++;
      $display("FAIL b2b_mstatus: got %h expected 00001888", f_mstatus);
    end
  endtask

  task automatic test_random();
    int          op;
    int          len;
    logic        is_trap;
    logic [11:0] a;
    logic        s;
    logic [31:0] d;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] target;
    r_mstatus = $urandom;
    r_mtvec   = $urandom;
    r_mepc    = $urandom;
    r_mcause  = $urandom;
    inst_write(12'h300, r_mstatus);
    inst_write(12'h305, r_mtvec);
    inst_write(12'h341, r_mepc);
    inst_write(12'h342, r_mcause);
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        a = addr_of($urandom_range(0, 4));
        s = 1'($urandom_range(0, 1));
        d = $urandom;
        ifc.inst_wr_en  = 1'b1;
        ifc.inst_wr_set = s;
        ifc.inst_wr_reg = a;
        ifc.inst_wr_bus = d;
        #1;
        n_tests++;
        if ({ifc.csr_wr_en, ifc.csr_wr_set, ifc.csr_wr_reg, ifc.csr_wr_bus} !== {1'b1, s, a, d}) begin
          n_fail++;
          $display("FAIL rand_mirror it%0d: got en=%b set=%b reg=%h bus=%h expected 1 %b %h %h",
                   it, ifc.csr_wr_en, ifc.csr_wr_set, ifc.csr_wr_reg, ifc.csr_wr_bus, s, a, d);
        end
        cyc();
        clear_in();
        case (a)
          12'h300: r_mstatus = s ? (r_mstatus | d) : d;
          12'h305: r_mtvec   = s ? (r_mtvec   | d) : d;
          12'h341: r_mepc    = s ? (r_mepc    | d) : d;
          12'h342: r_mcause  = s ? (r_mcause  | d) : d;
          default: ;
        endcase
      end else begin
        pc    = $urandom;
        cause = $urandom;
        is_trap = (op != 2);
        ifc.trap_req   = is_trap;
        ifc.mret_req   = (op != 1);
        ifc.trap_pc    = pc;
        ifc.trap_cause = cause;
        if (is_trap) begin
          len      = 4;
          target   = {r_mtvec[31:2], 2'b00};
          r_mepc   = pc;
          r_mcause = cause;
          r_mstatus[7]     = r_mstatus[3];
          r_mstatus[3]     = 1'b0;
          r_mstatus[12:11] = 2'b11;
        end else begin
          len    = 2;
          target = r_mepc;
          r_mstatus[3]     = r_mstatus[7];
          r_mstatus[7]     = 1'b1;
          r_mstatus[12:11] = 2'b11;
        end
        for (int k = 1; k <= len; k++) begin
          cyc();
          ifc.trap_req    = 1'($urandom_range(0, 1));
          ifc.mret_req    = 1'($urandom_range(0, 1));
          ifc.trap_pc     = $urandom;
          ifc.trap_cause  = $urandom;
          ifc.inst_wr_en  = 1'($urandom_range(0, 1));
          ifc.inst_wr_set = 1'($urandom_range(0, 1));
          ifc.inst_wr_reg = addr_of($urandom_range(0, 4));
          ifc.inst_wr_bus = $urandom;
          ifc.inst_rd_reg = addr_of($urandom_range(0, 4));
          #1;
          exp_rv = (k == len);
          exp_pc = (k == len) ? target : 32'h0;
          n_tests++;
          if ({ifc.busy, ifc.redirect_valid, ifc.redirect_pc} !== {1'b1, exp_rv, exp_pc}
              || (ifc.csr_wr_en === 1'b1 && ifc.csr_wr_set !== 1'b0)) begin
            n_fail++;
            $display("FAIL rand_seq it%0d k%0d: got busy=%b rv=%b rpc=%h set=%b expected busy=1 rv=%b rpc=%h set=0",
                     it, k, ifc.busy, ifc.redirect_valid, ifc.redirect_pc, ifc.csr_wr_set, exp_rv, exp_pc);
          end
        end
        cyc();
        clear_in();
        #1;
        n_tests++;
        if ({ifc.busy, ifc.redirect_valid, ifc.redirect_pc} !== 34'h0) begin
          n_fail++;
          $display("FAIL rand_end it%0d: got busy=%b rv=%b rpc=%h expected all zero",
                   it, ifc.busy, ifc.redirect_valid, ifc.redirect_pc);
        end
      end
      n_tests++;
      if ({f_mstatus, f_mtvec, f_mepc, f_mcause} !== {r_mstatus, r_mtvec, r_mepc, r_mcause}) begin
        n_fail++;
        $display("FAIL rand_csrs it%0d: got %h %h %h %h expected %h %h %h %h", it,
                 f_mstatus, f_mtvec, f_mepc, f_mcause, r_mstatus, r_mtvec, r_mepc, r_mcause);
      end
    end
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    test_reset();
    test_trap_basic();
    test_passthrough();
    test_trap_mret();
    test_simultaneous();
    test_inst_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
